// File: rtl/drs_chip_emulator_if.sv
// ----------------------------------------------------------------------------
// Module : drs_chip_emulator_if
// Brief  : DRS4 digital control bus between the drs controller and the chip.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface drs_chip_emulator_if;
    logic [3:0] drs_addr_i;
    logic       drs_denable_i;
    logic       drs_dwrite_i;
    logic       drs_rsrload_i;
    logic       drs_srclk_en_i;
    logic       drs_srin_i;
    logic       drs_srout_o;
    logic [9:0] stop_cell_o;
    logic [7:0] config_reg_o;
    logic [7:0] wsr_reg_o;
    logic [7:0] wcr_reg_o;
    logic [1:0] domino_state_o;
    logic       protocol_err_o;

    // Controller side
    modport master (
        output drs_addr_i, drs_denable_i, drs_dwrite_i, drs_rsrload_i,
               drs_srclk_en_i, drs_srin_i,
        input  drs_srout_o, stop_cell_o, config_reg_o, wsr_reg_o, wcr_reg_o,
               domino_state_o, protocol_err_o
    );

    // Chip side
    modport slave (
        input  drs_addr_i, drs_denable_i, drs_dwrite_i, drs_rsrload_i,
               drs_srclk_en_i, drs_srin_i,
        output drs_srout_o, stop_cell_o, config_reg_o, wsr_reg_o, wcr_reg_o,
               domino_state_o, protocol_err_o
    );
endinterface

`default_nettype wire

// File: rtl/drs_chip_emulator.sv
// ----------------------------------------------------------------------------
// Module : drs_chip_emulator
// Brief  : Chip-end responder model of the DRS4 control interface (domino
//          counter, stop-cell latch, read SR and config/WSR/WCR registers).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module drs_chip_emulator #(
    parameter int          NCELLS      = 1024,
    parameter int          CELL_STEP   = 1,
    parameter logic [7:0]  CONFIG_INIT = 8'hF8,
    parameter logic [7:0]  WSR_INIT    = 8'hFF,
    parameter logic [7:0]  WCR_INIT    = 8'hFF
) (
    input  wire logic           clock,
    input  wire logic           reset,
    drs_chip_emulator_if.slave  bus
);

    localparam logic [3:0] c_ADDR_CONFIG  = 4'b1100;
    localparam logic [3:0] c_ADDR_WSR     = 4'b1101;
    localparam logic [3:0] c_ADDR_WCR     = 4'b1110;
    localparam logic [3:0] c_ADDR_STANDBY = 4'b1111;
    localparam logic [3:0] c_ADDR_RSR_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2,
        ST_STANDBY = 2'd3
    } state_t;

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [9:0]  r_stop;
    logic [9:0]  r_rsr;
    logic [7:0]  r_cfg;
    logic [7:0]  r_wsr;
    logic [7:0]  r_wcr;
    logic        r_srout;
    logic        r_err;

    logic [10:0] w_cnt_sum;
    logic [9:0]  w_cnt_next;
    logic [9:0]  w_rsr_nxt;
    logic [7:0]  w_cfg_nxt;
    logic [7:0]  w_wsr_nxt;
    logic [7:0]  w_wcr_nxt;
    logic        w_srout_nxt;
    logic        w_err_set;

    // Modulo wrap without a divider: the step is always below NCELLS.
    assign w_cnt_sum  = {1'b0, r_cnt} + 11'(CELL_STEP);
    assign w_cnt_next = (w_cnt_sum >= 11'(NCELLS)) ? 10'(w_cnt_sum - 11'(NCELLS))
                                                   : w_cnt_sum[9:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_stop  <= '0;
        end else begin
            if (bus.drs_addr_i == c_ADDR_STANDBY) begin
                r_state <= ST_STANDBY;
            end else if (r_state == ST_STANDBY) begin
                r_state <= ST_IDLE;
            end else if (!bus.drs_denable_i) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.drs_dwrite_i) r_state <= ST_RUNNING;
                    end
                    ST_RUNNING: begin
                        if (!bus.drs_dwrite_i) begin
                            r_state <= ST_STOPPED;
                            r_stop  <= r_cnt;
                        end else begin
                            r_cnt   <= w_cnt_next;
                        end
                    end
                    ST_STOPPED: begin
                        if (bus.drs_dwrite_i) r_state <= ST_RUNNING;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Load takes priority over a coincident shift beat.
    always_comb begin
        w_rsr_nxt = r_rsr;
        w_cfg_nxt = r_cfg;
        w_wsr_nxt = r_wsr;
        w_wcr_nxt = r_wcr;
        if (bus.drs_rsrload_i && (bus.drs_addr_i <= c_ADDR_RSR_MAX)) begin
            w_rsr_nxt = r_stop;
        end else if (bus.drs_srclk_en_i) begin
            w_rsr_nxt = {r_rsr[8:0], 1'b0};
        end
        if (bus.drs_srclk_en_i) begin
            case (bus.drs_addr_i)
                c_ADDR_CONFIG: w_cfg_nxt = {r_cfg[6:0], bus.drs_srin_i};
                c_ADDR_WSR:    w_wsr_nxt = {r_wsr[6:0], bus.drs_srin_i};
                c_ADDR_WCR:    w_wcr_nxt = {r_wcr[6:0], bus.drs_srin_i};
                default:       ;
            endcase
        end
    end

    // srout follows the post-edge register contents so it tracks the visible MSB.
    always_comb begin
        case (bus.drs_addr_i)
            c_ADDR_CONFIG: w_srout_nxt = w_cfg_nxt[7];
            c_ADDR_WSR:    w_srout_nxt = w_wsr_nxt[7];
            c_ADDR_WCR:    w_srout_nxt = w_wcr_nxt[7];
            default:       w_srout_nxt = w_rsr_nxt[9];
        endcase
    end

    assign w_err_set = (r_state == ST_RUNNING) &&
                       (bus.drs_rsrload_i ||
                        (bus.drs_srclk_en_i &&
                         ((bus.drs_addr_i == c_ADDR_CONFIG) ||
                          (bus.drs_addr_i == c_ADDR_WCR))));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsr   <= '0;
            r_cfg   <= CONFIG_INIT;
            r_wsr   <= WSR_INIT;
            r_wcr   <= WCR_INIT;
            r_srout <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rsr   <= w_rsr_nxt;
            r_cfg   <= w_cfg_nxt;
            r_wsr   <= w_wsr_nxt;
            r_wcr   <= w_wcr_nxt;
            r_srout <= w_srout_nxt;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign bus.drs_srout_o    = r_srout;
    assign bus.stop_cell_o    = r_stop;
    assign bus.config_reg_o   = r_cfg;
    assign bus.wsr_reg_o      = r_wsr;
    assign bus.wcr_reg_o      = r_wcr;
    assign bus.domino_state_o = r_state;
    assign bus.protocol_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_drs_chip_emulator.sv
// ----------------------------------------------------------------------------
// Module : tb_drs_chip_emulator
// Brief  : Self-checking bench for drs_chip_emulator with a behavioural model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_drs_chip_emulator;

    localparam int NCELLS    = 1024;
    localparam int CELL_STEP = 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    drs_chip_emulator_if bus();

    drs_chip_emulator #(
        .NCELLS      (NCELLS),
        .CELL_STEP   (CELL_STEP),
        .CONFIG_INIT (8'hF8),
        .WSR_INIT    (8'hFF),
        .WCR_INIT    (8'hFF)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: state as an integer, counter as plain modulo arithmetic.
    int         m_state;
    int         m_cnt;
    logic [9:0] m_stop;
    logic [9:0] m_rsr;
    logic [7:0] m_cfg;
    logic [7:0] m_wsr;
    logic [7:0] m_wcr;
    logic       m_srout;
    logic       m_err;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_stop = '0; m_rsr = '0;
        m_cfg = 8'hF8; m_wsr = 8'hFF; m_wcr = 8'hFF; m_srout = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        int         a;
        int         nxt;
        logic [9:0] rsr_after;
        a   = int'(bus.drs_addr_i);
        nxt = m_state;
        if (m_state == 1 && (bus.drs_rsrload_i ||
            (bus.drs_srclk_en_i && (a == 12 || a == 14))))
            m_err = 1'b1;
        if (bus.drs_rsrload_i && a <= 9) rsr_after = m_stop;
        else if (bus.drs_srclk_en_i)     rsr_after = 10'((int'(m_rsr) * 2) % 1024);
        else                             rsr_after = m_rsr;
        m_rsr = rsr_after;
        if (bus.drs_srclk_en_i) begin
            if (a == 12) m_cfg = {m_cfg[6:0], bus.drs_srin_i};
            if (a == 13) m_wsr = {m_wsr[6:0], bus.drs_srin_i};
            if (a == 14) m_wcr = {m_wcr[6:0], bus.drs_srin_i};
        end
        if (a == 15)                 nxt = 3;
        else if (m_state == 3)       nxt = 0;
        else if (!bus.drs_denable_i) nxt = 0;
        else if (m_state == 0 && bus.drs_dwrite_i) nxt = 1;
        else if (m_state == 2 && bus.drs_dwrite_i) nxt = 1;
        else if (m_state == 1) begin
            if (!bus.drs_dwrite_i) begin
                nxt    = 2;
                m_stop = 10'(m_cnt);
            end else begin
                m_cnt = (m_cnt + CELL_STEP) % NCELLS;
            end
        end
        m_state = nxt;
        if (a == 12)      m_srout = m_cfg[7];
        else if (a == 13) m_srout = m_wsr[7];
        else if (a == 14) m_srout = m_wcr[7];
        else              m_srout = m_rsr[9];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] a, input logic de, input logic dw,
                          input logic ld, input logic sc, input logic si);
        bus.drs_addr_i     = a;
        bus.drs_denable_i  = de;
        bus.drs_dwrite_i   = dw;
        bus.drs_rsrload_i  = ld;
        bus.drs_srclk_en_i = sc;
        bus.drs_srin_i     = si;
    endtask

    task automatic apply_reset();
        set_in(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 6;
        if (bus.config_reg_o !== 8'hF8) begin n_errors++; $display("FAIL reset_config got=%h exp=f8", bus.config_reg_o); end
        if (bus.wsr_reg_o !== 8'hFF) begin n_errors++; $display("FAIL reset_wsr got=%h exp=ff", bus.wsr_reg_o); end
        if (bus.wcr_reg_o !== 8'hFF) begin n_errors++; $display("FAIL reset_wcr got=%h exp=ff", bus.wcr_reg_o); end
        if (bus.domino_state_o !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", bus.domino_state_o); end
        if (bus.drs_srout_o !== 1'b0) begin n_errors++; $display("FAIL reset_srout got=%b exp=0", bus.drs_srout_o); end
        if (bus.protocol_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", bus.protocol_err_o); end
    endtask

    task automatic test_shift_config();
        logic [7:0] exp_byte;
        exp_byte = 8'hAA;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, exp_byte[7-i]);
            tick();
        end
        n_checks += 2;
        if (bus.config_reg_o !== 8'hAA) begin n_errors++; $display("FAIL cfg_value got=%h exp=aa", bus.config_reg_o); end
        if (bus.wsr_reg_o !== 8'hFF) begin n_errors++; $display("FAIL cfg_wsr_untouched got=%h exp=ff", bus.wsr_reg_o); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                set_in(4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                tick();
            end
            n_checks++;
            if (bus.drs_srout_o !== exp_byte[7-k]) begin
                n_errors++;
                $display("FAIL cfg_readback bit=%0d got=%b exp=%b", 7-k, bus.drs_srout_o, exp_byte[7-k]);
            end
        end
    endtask

    task automatic test_domino_stop();
        apply_reset();
        set_in(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) tick();
        set_in(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks += 2;
        if (bus.stop_cell_o !== 10'd999) begin n_errors++; $display("FAIL stop_cell got=%0d exp=999", bus.stop_cell_o); end
        if (bus.domino_state_o !== 2'd2) begin n_errors++; $display("FAIL stop_state got=%0d exp=2", bus.domino_state_o); end
    endtask

    task automatic test_wrap_readout();
        logic [9:0] exp_cell;
        exp_cell = 10'((1030 - 1) % 1024);
        apply_reset();
        set_in(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1030; i++) tick();
        set_in(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.stop_cell_o !== exp_cell) begin n_errors++; $display("FAIL wrap_cell got=%0d exp=%0d", bus.stop_cell_o, exp_cell); end
        // Load and shift together: load must win.
        set_in(4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                set_in(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                tick();
            end
            n_checks++;
            if (bus.drs_srout_o !== exp_cell[9-k]) begin
                n_errors++;
                $display("FAIL rsr_readout bit=%0d got=%b exp=%b", 9-k, bus.drs_srout_o, exp_cell[9-k]);
            end
        end
        n_checks++;
        if (bus.protocol_err_o !== 1'b0) begin n_errors++; $display("FAIL readout_err got=%b exp=0", bus.protocol_err_o); end
    endtask

    task automatic test_errors();
        apply_reset();
        set_in(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        set_in(4'b1101, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.protocol_err_o !== 1'b0) begin n_errors++; $display("FAIL err_wsr_running got=%b exp=0", bus.protocol_err_o); end
        set_in(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.protocol_err_o !== 1'b1) begin n_errors++; $display("FAIL err_rsrload_running got=%b exp=1", bus.protocol_err_o); end
        set_in(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        n_checks += 2;
        if (bus.protocol_err_o !== 1'b1) begin n_errors++; $display("FAIL err_sticky got=%b exp=1", bus.protocol_err_o); end
        if (bus.domino_state_o !== 2'd0) begin n_errors++; $display("FAIL err_idle_state got=%0d exp=0", bus.domino_state_o); end
        apply_reset();
        set_in(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        set_in(4'b1110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus.protocol_err_o !== 1'b1) begin n_errors++; $display("FAIL err_wcr_running got=%b exp=1", bus.protocol_err_o); end
    endtask

    task automatic test_standby();
        apply_reset();
        set_in(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 101; i++) tick();
        set_in(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) tick();
        n_checks++;
        if (bus.domino_state_o !== 2'd3) begin n_errors++; $display("FAIL standby_state got=%0d exp=3", bus.domino_state_o); end
        set_in(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.domino_state_o !== 2'd0) begin n_errors++; $display("FAIL standby_exit got=%0d exp=0", bus.domino_state_o); end
        for (int i = 0; i < 21; i++) tick();
        set_in(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.stop_cell_o !== 10'd120) begin n_errors++; $display("FAIL standby_frozen got=%0d exp=120", bus.stop_cell_o); end
    endtask

    task automatic test_reset_mid_shift();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(4'b1100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks += 4;
        if (bus.config_reg_o !== 8'hF8) begin n_errors++; $display("FAIL midrst_config got=%h exp=f8", bus.config_reg_o); end
        if (bus.domino_state_o !== 2'd0) begin n_errors++; $display("FAIL midrst_state got=%0d exp=0", bus.domino_state_o); end
        if (bus.protocol_err_o !== 1'b0) begin n_errors++; $display("FAIL midrst_err got=%b exp=0", bus.protocol_err_o); end
        if (bus.drs_srout_o !== 1'b0) begin n_errors++; $display("FAIL midrst_srout got=%b exp=0", bus.drs_srout_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] a;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            a = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            set_in(a,
                   1'($urandom_range(0, 9) != 0),
                   1'($urandom_range(0, 7) != 0),
                   1'($urandom_range(0, 15) == 0),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            tick();
            n_checks += 7;
            if (bus.drs_srout_o !== m_srout) begin n_errors++; $display("FAIL rand_srout cyc=%0d got=%b exp=%b", c, bus.drs_srout_o, m_srout); end
            if (bus.domino_state_o !== 2'(m_state)) begin n_errors++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", c, bus.domino_state_o, m_state); end
            if (bus.stop_cell_o !== m_stop) begin n_errors++; $display("FAIL rand_stop cyc=%0d got=%0d exp=%0d", c, bus.stop_cell_o, m_stop); end
            if (bus.config_reg_o !== m_cfg) begin n_errors++; $display("FAIL rand_cfg cyc=%0d got=%h exp=%h", c, bus.config_reg_o, m_cfg); end
            if (bus.wsr_reg_o !== m_wsr) begin n_errors++; $display("FAIL rand_wsr cyc=%0d got=%h exp=%h", c, bus.wsr_reg_o, m_wsr); end
            if (bus.wcr_reg_o !== m_wcr) begin n_errors++; $display("FAIL rand_wcr cyc=%0d got=%h exp=%h", c, bus.wcr_reg_o, m_wcr); end
            if (bus.protocol_err_o !== m_err) begin n_errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, bus.protocol_err_o, m_err); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        set_in(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_shift_config();
        test_domino_stop();
        test_wrap_readout();
        test_errors();
        test_standby();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
